// File: rtl/load_store_unit.sv
// load_store_unit
//
// Bridges the RV32I memory stage to a request/grant/response data memory with
// wait states. One core request becomes one memory transaction with byte-lane
// masking, store-data lane replication and load sign/zero extension. The core is
// stalled until the access completes. Misaligned, illegal and timed-out accesses
// complete with an error response and (for decode errors) never reach memory.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i         core request, held until rsp_valid_o
//   req_store_i         1 = store, 0 = load
//   req_funct3_i        RV32I funct3 of the load/store
//   req_addr_i          byte address
//   req_wdata_i         store data (rs2)
//   stall_o             core must hold PC and request fields
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         extended load data, 0 for stores and errors
//   rsp_err_o           error qualifier for rsp_valid_o
//   mem_req_o           memory request, held until mem_gnt_i or timeout
//   mem_we_o            write enable
//   mem_mask_o          byte-lane enables
//   mem_addr_o          word address (low 2 bits 0)
//   mem_wdata_o         lane-replicated store data
//   mem_gnt_i           memory accepted the request
//   mem_rvalid_i        load data valid
//   mem_rdata_i         load word

module load_store_unit #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned TIMEOUT       = 16,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              stall_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_mask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    // The counter only has to reach TIMEOUT-1: the timeout fires in the cycle
    // that would make it TIMEOUT.
    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Request decode (combinational, only consumed in IDLE)
    logic              f3_legal;
    logic              size_half;
    logic              size_word;
    logic              misaligned;
    logic              access_ok;
    logic [ADDR_W-1:0] addr_acc;
    logic [3:0]        mask_d;
    logic [31:0]       wdata_d;

    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~req_store_i;
            default:                f3_legal = 1'b0;
        endcase

        size_half  = (req_funct3_i[1:0] == 2'b01);
        size_word  = (req_funct3_i[1:0] == 2'b10);
        misaligned = (size_half & req_addr_i[0]) | (size_word & (|req_addr_i[1:0]));
        access_ok  = f3_legal & ~(MISALIGN_TRAP & misaligned);

        // Forcing alignment is harmless when trapping: misaligned requests
        // never issue, so the adjusted address is only ever used untrapped.
        addr_acc = req_addr_i;
        if (size_half) addr_acc[0] = 1'b0;
        if (size_word) addr_acc[1:0] = 2'b00;

        case (req_funct3_i[1:0])
            2'b00: begin
                mask_d  = 4'b0001 << addr_acc[1:0];
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                mask_d  = 4'b0011 << addr_acc[1:0];
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            default: begin
                mask_d  = 4'b1111;
                wdata_d = req_wdata_i;
            end
        endcase
    end

    // Load lane select and extension from the registered access
    logic [31:0] lane;
    logic [31:0] ld_ext;

    always_comb begin
        lane = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'b0, lane[7:0]};
            3'b101:  ld_ext = {16'b0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            mask_q   <= 4'b0000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q   <= addr_acc;
                        funct3_q <= req_funct3_i;
                        store_q  <= req_store_i;
                        mask_q   <= mask_d;
                        wdata_q  <= wdata_d;
                        rdata_q  <= 32'h0;
                        cnt_q    <= '0;
                        err_q    <= ~access_ok;
                        state_q  <= access_ok ? StReq : StResp;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A store grant completes the access and beats the timeout;
                    // a load grant does not, since the load still owes rvalid.
                    // Any rvalid in this state is ignored.
                    if (mem_gnt_i && store_q) begin
                        state_q <= StResp;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else if (mem_gnt_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid_i) begin
                        rdata_q <= ld_ext;
                        state_q <= StResp;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, except stall_o which
    // must rise in the accept cycle.
    always_comb begin
        stall_o     = ((state_q == StIdle) & req_valid_i) | (state_q == StReq) |
                      (state_q == StWait);
        rsp_valid_o = (state_q == StResp);
        rsp_err_o   = (state_q == StResp) & err_q;
        rsp_rdata_o = (state_q == StResp) ? rdata_q : 32'h0;
        mem_req_o   = (state_q == StReq);
        mem_we_o    = (state_q == StReq) & store_q;
        mem_mask_o  = (state_q == StReq) ? mask_q : 4'b0000;
        mem_addr_o  = (state_q == StReq) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata_o = (state_q == StReq) ? wdata_q : 32'h0;
    end

endmodule
